// File: rtl/output_pkg.sv
// Shared definitions for the output hold-off block: state encoding and
// parameter range checking for the minimum on/off hold times.
package output_pkg;

  localparam logic [1:0] ST_IDLE_LO = 2'd0;
  localparam logic [1:0] ST_HOLD_HI = 2'd1;
  localparam logic [1:0] ST_IDLE_HI = 2'd2;
  localparam logic [1:0] ST_HOLD_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE_LO = ST_IDLE_LO,
    HOLD_HI = ST_HOLD_HI,
    IDLE_HI = ST_IDLE_HI,
    HOLD_LO = ST_HOLD_LO
  } state_e;

  // True when a hold time fits a WIDTH-bit counter as 1..2**WIDTH-1.
  function automatic bit hold_in_range(input int val, input int width);
    return (val >= 1) && (longint'(val) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter for the minimum-hold interval: reloads on load, decrements
// while run is high, and stops at zero so it never wraps.
module hold_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             run,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/output_holdoff.sv
// Output pin driver enforcing minimum on/off times: short requests are
// stretched (never dropped) and enable=0 forces a safe level at once.
module output_holdoff
  import output_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MIN_ON     = 1000,
  parameter int MIN_OFF    = 1000,
  parameter bit SAFE_LEVEL = 1'b0,
  parameter bit INVERT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic enable,
  output logic pin,
  output logic level,
  output logic busy,
  output logic pending
);

  if (!hold_in_range(MIN_ON, WIDTH)) begin : g_bad_min_on
    $error("output_holdoff: MIN_ON must be in 1..2**WIDTH-1");
  end
  if (!hold_in_range(MIN_OFF, WIDTH)) begin : g_bad_min_off
    $error("output_holdoff: MIN_OFF must be in 1..2**WIDTH-1");
  end

  // Counter reloads with MIN-1 so the level lasts exactly MIN cycles.
  localparam logic [WIDTH-1:0] ON_RELOAD  = WIDTH'(MIN_ON - 1);
  localparam logic [WIDTH-1:0] OFF_RELOAD = WIDTH'(MIN_OFF - 1);
  localparam state_e SAFE_STATE = SAFE_LEVEL ? IDLE_HI : IDLE_LO;

  state_e           state_q, state_d;
  logic             level_q, level_d;
  logic             pend_q, pend_d;
  logic             pin_q;
  logic             busy_q;
  logic             tmr_load;
  logic [WIDTH-1:0] tmr_val;
  logic             tmr_run;
  logic             tmr_done;

  hold_timer #(.WIDTH(WIDTH)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_run  = 1'b0;
    if (!enable) begin
      state_d  = SAFE_STATE;
      level_d  = SAFE_LEVEL;
      pend_d   = 1'b0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE_LO: begin
          if (din) begin
            state_d  = HOLD_HI;
            level_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = ON_RELOAD;
          end
        end
        HOLD_HI: begin
          if (!tmr_done) begin
            tmr_run = 1'b1;
            if (!din) pend_d = 1'b1;
          end else if (!din || pend_q) begin
            state_d  = HOLD_LO;
            level_d  = 1'b0;
            pend_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = OFF_RELOAD;
          end else begin
            state_d = IDLE_HI;
            pend_d  = 1'b0;
          end
        end
        IDLE_HI: begin
          if (!din) begin
            state_d  = HOLD_LO;
            level_d  = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = OFF_RELOAD;
          end
        end
        HOLD_LO: begin
          if (!tmr_done) begin
            tmr_run = 1'b1;
            if (din) pend_d = 1'b1;
          end else if (din || pend_q) begin
            state_d  = HOLD_HI;
            level_d  = 1'b1;
            pend_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = ON_RELOAD;
          end else begin
            state_d = IDLE_LO;
            pend_d  = 1'b0;
          end
        end
        default: begin
          state_d = SAFE_STATE;
          level_d = SAFE_LEVEL;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // busy and pin are computed from next-state so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LO;
      level_q <= 1'b0;
      pend_q  <= 1'b0;
      pin_q   <= INVERT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      pin_q   <= level_d ^ INVERT;
      busy_q  <= (state_d == HOLD_HI) || (state_d == HOLD_LO);
    end
  end

  assign pin     = pin_q;
  assign level   = level_q;
  assign busy    = busy_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_output_holdoff.sv
// Randomized and directed bench for output_holdoff with a reference model
// tracking level age against the minimum on/off times.
module tb_output_holdoff;

  localparam int W   = 8;
  localparam int ON  = 4;
  localparam int OFF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic enable = 1'b1;
  logic pin_a, level_a, busy_a, pending_a;
  logic pin_b, level_b, busy_b, pending_b;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  bit m_level;
  bit m_pend;
  int m_age;

  always #5 clk = ~clk;

  output_holdoff #(.WIDTH(W), .MIN_ON(ON), .MIN_OFF(OFF), .SAFE_LEVEL(1'b0), .INVERT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .din(din), .enable(enable),
    .pin(pin_a), .level(level_a), .busy(busy_a), .pending(pending_a)
  );

  output_holdoff #(.WIDTH(W), .MIN_ON(ON), .MIN_OFF(OFF), .SAFE_LEVEL(1'b0), .INVERT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .din(din), .enable(enable),
    .pin(pin_b), .level(level_b), .busy(busy_b), .pending(pending_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cur_min();
    return m_level ? ON : OFF;
  endfunction

  task automatic model_reset();
    m_level = 1'b0;
    m_age   = 1000;
    m_pend  = 1'b0;
  endtask

  // Level may only flip once it has been held its minimum; any opposite
  // request seen during the hold is remembered and honoured at hold end.
  task automatic model_step(input bit d, input bit e);
    if (!e) begin
      m_level = 1'b0;
      m_age   = 1000;
      m_pend  = 1'b0;
    end else if (m_age < cur_min()) begin
      if (d != m_level) m_pend = 1'b1;
      m_age++;
    end else begin
      if ((d != m_level) || m_pend) begin
        m_level = !m_level;
        m_age   = 1;
      end else begin
        m_age = 1000;
      end
      m_pend = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("level_a", level_a, m_level);
    chk("pin_a", pin_a, m_level);
    chk("busy_a", busy_a, m_age <= cur_min());
    chk("pend_a", pending_a, m_pend);
    chk("level_b", level_b, m_level);
    chk("pin_b", pin_b, !m_level);
    chk("busy_b", busy_b, m_age <= cur_min());
    chk("pend_b", pending_b, m_pend);
  endtask

  task automatic cyc(input bit d, input bit e);
    din = d;
    enable = e;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(d, e);
    #1;
    compare_all();
    ncyc++;
    $display("cyc %0d rst=%0d din=%0d en=%0d level=%0d pin=%0d/%0d busy=%0d pend=%0d",
             ncyc, rst, d, e, level_a, pin_a, pin_b, busy_a, pending_a);
  endtask

  initial begin
    int hi;
    int lo;
    int run;
    bit prev;
    bit d;
    bit e;

    model_reset();
    // Scenario 1: reset with din=1, then release.
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("s1_rst_pin", pin_a, 0);
    chk("s1_rst_busy", busy_a, 0);
    chk("s6_rst_pin_inv", pin_b, 1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1);
      if (i == 0) chk("s1_pin_rise", pin_a, 1);
      chk("s1_busy", busy_a, i < 4);
    end

    // Scenario 2: single-cycle request is stretched to MIN_ON.
    repeat (8) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    hi = pin_a ? 1 : 0;
    repeat (12) begin
      cyc(1'b0, 1'b1);
      hi += pin_a ? 1 : 0;
    end
    chk("s2_hi_len", hi, 4);
    chk("s2_end_lo", pin_a, 0);

    // Scenario 3: low glitch inside HOLD_HI is latched and replayed.
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("s3_pending", pending_a, 1);
    lo = 0;
    repeat (10) begin
      cyc(1'b1, 1'b1);
      lo += pin_a ? 0 : 1;
    end
    chk("s3_lo_len", lo, 3);
    chk("s3_end_hi", pin_a, 1);

    // Scenario 4: din toggles every cycle.
    prev = level_a;
    run = 100;
    for (int i = 0; i < 40; i++) begin
      cyc(i[0], 1'b1);
      if (level_a != prev) begin
        chk("s4_run_len", run >= (prev ? ON : OFF), 1);
        run = 1;
        prev = level_a;
      end else begin
        run++;
      end
    end

    // Scenario 5: enable drop in the second cycle of HOLD_HI.
    repeat (10) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("s5_safe_pin", pin_a, 0);
    chk("s5_safe_busy", busy_a, 0);
    chk("s5_safe_pend", pending_a, 0);
    cyc(1'b1, 1'b0);
    chk("s5_din_ignored", pin_a, 0);
    cyc(1'b1, 1'b1);
    chk("s5_resume_pin", pin_a, 1);

    // Scenario 6: async reset in the middle of HOLD_LO with pend set.
    repeat (8) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("s6_in_hold_lo", busy_a, 1);
    chk("s6_pend_set", pending_a, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("s6_async_pin_inv", pin_b, 1);
    chk("s6_async_pin", pin_a, 0);
    chk("s6_async_busy", busy_a, 0);
    chk("s6_async_pend", pending_a, 0);
    cyc(1'b1, 1'b1);
    rst = 1'b0;

    // Randomized run.
    d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) d = !d;
      e = ($urandom_range(0, 29) != 0);
      cyc(d, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
